// File: rtl/pc_word_serializer.sv
// rtl/pc_word_serializer.sv - splits decoded BD words into one or two 24-bit PC word chunks
module pc_word_serializer #(
  parameter logic [12:0] LONG_LEAF_MASK = 13'h0000,
  parameter int          NCOUNT         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        dec_in_leaf_code,
  input  logic [37:0]       dec_in_payload,
  input  logic              dec_in_v,
  output logic              dec_in_a,
  output logic [7:0]        ser_out_code,
  output logic [23:0]       ser_out_payload,
  output logic              ser_out_v,
  input  logic              ser_out_a,
  output logic [NCOUNT-1:0] words_sent
);

  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;

  state_t      state, state_nx;
  logic [3:0]  leaf_q;
  logic [37:0] payload_q;
  logic        long_q;
  logic        leaf_long;
  logic        dec_xfer;
  logic        ser_xfer;
  logic        last_chunk;

  // leaf codes 13..15 have no mask bit and are always short
  always_comb begin
    leaf_long = 1'b0;
    if (dec_in_leaf_code < 4'd13) leaf_long = LONG_LEAF_MASK[dec_in_leaf_code];
  end

  assign last_chunk = (state == SEND_HI) || (state == SEND_LO && !long_q);
  // ser_out_v is 1 in both send states, so ser_out_a alone marks the transfer
  assign dec_in_a   = !reset && ((state == IDLE) || (last_chunk && ser_out_a));
  assign dec_xfer   = dec_in_v && dec_in_a;
  assign ser_xfer   = ser_out_v && ser_out_a;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (dec_xfer) state_nx = SEND_LO;
      SEND_LO: if (ser_xfer) begin
                 if (long_q)        state_nx = SEND_HI;
                 else if (dec_xfer) state_nx = SEND_LO;
                 else               state_nx = IDLE;
               end
      SEND_HI: if (ser_xfer) state_nx = dec_xfer ? SEND_LO : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ser_out_v       = 1'b0;
    ser_out_code    = 8'h00;
    ser_out_payload = 24'h000000;
    case (state)
      SEND_LO: begin
        ser_out_v       = 1'b1;
        ser_out_code    = {leaf_q, 2'b00, long_q, 1'b0};
        ser_out_payload = payload_q[23:0];
      end
      SEND_HI: begin
        ser_out_v       = 1'b1;
        ser_out_code    = {leaf_q, 2'b00, 1'b1, 1'b1};
        ser_out_payload = {10'b0, payload_q[37:24]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leaf_q    <= 4'h0;
      payload_q <= 38'h0;
      long_q    <= 1'b0;
    end else if (dec_xfer) begin
      leaf_q    <= dec_in_leaf_code;
      payload_q <= dec_in_payload;
      long_q    <= leaf_long;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         words_sent <= '0;
    else if (ser_xfer) words_sent <= words_sent + 1'b1;
  end

endmodule

// File: tb/tb_pc_word_serializer.sv
// tb/tb_pc_word_serializer.sv - scoreboard bench for pc_word_serializer
module tb_pc_word_serializer;

  localparam logic [12:0] MASK = 13'h0020;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  dec_leaf = 4'h0;
  logic [37:0] dec_payload = 38'h0;
  logic        dec_v = 1'b0;
  logic        ser_a = 1'b1;
  logic        dec_a, dec_a_w;
  logic [7:0]  ser_code, ser_code_w;
  logic [23:0] ser_payload, ser_payload_w;
  logic        ser_v, ser_v_w;
  logic [15:0] words_sent;
  logic [3:0]  words_sent_w;

  int          checks = 0;
  int          errors = 0;
  int          sent_model = 0;
  int          cyc = 0;
  int          cyc_start;
  int          ws_start;
  bit          mon_en = 1'b0;
  logic [31:0] exp_q[$];

  pc_word_serializer #(.LONG_LEAF_MASK(MASK), .NCOUNT(16)) dut (
    .clk(clk), .reset(reset),
    .dec_in_leaf_code(dec_leaf), .dec_in_payload(dec_payload), .dec_in_v(dec_v), .dec_in_a(dec_a),
    .ser_out_code(ser_code), .ser_out_payload(ser_payload), .ser_out_v(ser_v), .ser_out_a(ser_a),
    .words_sent(words_sent)
  );

  pc_word_serializer #(.LONG_LEAF_MASK(MASK), .NCOUNT(4)) dut_w (
    .clk(clk), .reset(reset),
    .dec_in_leaf_code(dec_leaf), .dec_in_payload(dec_payload), .dec_in_v(dec_v), .dec_in_a(dec_a_w),
    .ser_out_code(ser_code_w), .ser_out_payload(ser_payload_w), .ser_out_v(ser_v_w), .ser_out_a(ser_a),
    .words_sent(words_sent_w)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [3:0] leaf, input logic [37:0] pl);
    logic [12:0] m;
    logic        lng;
    m   = MASK;
    lng = (leaf < 4'd13) ? m[leaf] : 1'b0;
    exp_q.push_back({leaf, 2'b00, lng, 1'b0, pl[23:0]});
    if (lng) exp_q.push_back({leaf, 4'b0011, 10'b0, pl[37:24]});
  endtask

  // scoreboard: words pushed when accepted, chunks popped when transferred
  always @(negedge clk) begin
    logic [31:0] e;
    if (mon_en && !reset) begin
      if (ser_v && ser_a) begin
        if (exp_q.size() == 0) check("unexpected_xfer", ser_v, 1'b0);
        else begin
          e = exp_q.pop_front();
          check("chunk", {ser_code, ser_payload}, e);
        end
        sent_model++;
      end
      if (dec_v && dec_a) push_word(dec_leaf, dec_payload);
    end
  end

  // called just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [3:0] leaf, input logic [37:0] pl);
    int n;
    dec_leaf    = leaf;
    dec_payload = pl;
    dec_v       = 1'b1;
    n = 0;
    @(negedge clk);
    while (!dec_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!dec_a) check("accept_timeout", dec_a, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] leaves [8];
    leaves = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd13, 4'd15};

    repeat (2) @(negedge clk);
    check("rst_v", ser_v, 1'b0);
    check("rst_code", ser_code, 8'h00);
    check("rst_payload", ser_payload, 24'h0);
    check("rst_words", words_sent, 16'h0);
    check("rst_dec_a", dec_a, 1'b0);
    reset  = 1'b0;
    mon_en = 1'b1;
    step();
    check("dec_a_after_rst", dec_a, 1'b1);

    // short word
    send(4'd3, 38'h0000ABCDEF);
    dec_v = 1'b0;
    check("short_code", ser_code, 8'h30);
    check("short_payload", ser_payload, 24'hABCDEF);
    check("short_v", ser_v, 1'b1);
    step();
    check("short_words", words_sent, 16'd1);
    check("short_idle_v", ser_v, 1'b0);

    // long word
    send(4'd5, 38'h3FFF123456);
    dec_v = 1'b0;
    check("long_lo_code", ser_code, 8'h52);
    check("long_lo_payload", ser_payload, 24'h123456);
    step();
    check("long_hi_code", ser_code, 8'h53);
    check("long_hi_payload", ser_payload, 24'h003FFF);
    step();
    check("long_words", words_sent, 16'd3);

    // backpressure in SEND_HI
    ser_a = 1'b0;
    send(4'd5, 38'h1555001234);
    dec_v = 1'b0;
    ser_a = 1'b1;
    step();
    ser_a = 1'b0;
    dec_leaf = 4'd2;
    dec_v    = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_v", ser_v, 1'b1);
      check("bp_code", ser_code, 8'h53);
      check("bp_payload", ser_payload, 24'h001555);
      check("bp_dec_a", dec_a, 1'b0);
      check("bp_words", words_sent, 16'd4);
    end
    dec_v = 1'b0;
    @(posedge clk); #1;
    ser_a = 1'b1;
    step();
    check("bp_words_after", words_sent, 16'd5);
    check("bp_idle_v", ser_v, 1'b0);

    // streaming short words, including leaves 13 and 15
    cyc_start = cyc;
    ws_start  = sent_model;
    for (int i = 0; i < 8; i++) send(leaves[i], {14'h3ABC, 24'(i * 24'h010203)});
    check("stream_cycles", cyc - cyc_start, 8);
    dec_v = 1'b0;
    check("stream_last_v", ser_v, 1'b1);
    step();
    check("stream_count", sent_model - ws_start, 8);
    check("stream_words", words_sent, 16'd13);
    check("stream_idle_v", ser_v, 1'b0);

    // reset while in SEND_HI
    ser_a = 1'b0;
    send(4'd5, 38'h2200ABCDEF);
    dec_v = 1'b0;
    ser_a = 1'b1;
    step();
    ser_a = 1'b0;
    check("pre_rst_code", ser_code, 8'h53);
    reset = 1'b1;
    #1;
    exp_q.delete();
    sent_model = 0;
    check("midrst_v", ser_v, 1'b0);
    check("midrst_words", words_sent, 16'h0);
    check("midrst_dec_a", dec_a, 1'b0);
    check("midrst_code", ser_code, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    ser_a = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_v", ser_v, 1'b0);
    end
    step();

    // counter wrap on the 4-bit instance
    for (int i = 0; i < 17; i++) send(4'(i % 5), 38'(i));
    dec_v = 1'b0;
    step();
    check("wrap_words_w", words_sent_w, 4'd1);
    check("wrap_words", words_sent, 16'd17);
    check("wrap_model", words_sent, sent_model[15:0]);
    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_word_serializer.md
PC_WORD_SERIALIZER -- requirements
Module: pc_word_serializer

Interface
Parameters:
REQ-001 SHALL have parameter LONG_LEAF_MASK, default 13'h0000, meaning bit k=1 marks leaf_code k as a two-chunk (payload >24 bit) word.
REQ-002 SHALL have parameter NCOUNT, default 16, meaning width of the sent-word counter.

Ports:
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port dec_in  DecodedBDWordChannel  n/a  input channel: leaf_code[3:0], payload[37:0], v driven by sender, a driven by this block.
REQ-006 SHALL have port ser_out  SerializedPCWordChannel  n/a  output channel: code[7:0], payload[23:0], v driven by this block, a driven by receiver.
REQ-007 SHALL have port words_sent  output  NCOUNT  count of completed ser_out transfers, wrapping.

Function
REQ-008 SHALL treat a transfer on either channel as occurring exactly in a cycle where v=1 and a=1 on that channel.
REQ-009 SHALL implement FSM states IDLE, SEND_LO, SEND_HI.
REQ-010 SHALL capture dec_in leaf_code and payload into an internal register on each dec_in transfer.
REQ-011 SHALL treat a captured word as long when LONG_LEAF_MASK[leaf_code]=1; leaf_code 13..15 SHALL be treated as short.
REQ-012 SHALL drive dec_in.a=1 in IDLE, and in SEND_LO for a short word or in SEND_HI, only in a cycle where ser_out transfers; otherwise 0.
REQ-013 SHALL not combinationally depend dec_in.a on dec_in.v.
REQ-014 SHALL transition IDLE->SEND_LO on a dec_in transfer; ser_out.v SHALL rise the following cycle (latency 1).
REQ-015 In SEND_LO, SHALL drive ser_out.payload=payload[23:0], code={leaf_code, 2'b00, long, 1'b0}.
REQ-016 In SEND_HI, SHALL drive ser_out.payload={10'b0, payload[37:24]}, code={leaf_code, 2'b00, 1'b1, 1'b1}.
REQ-017 On ser_out transfer in SEND_LO with a long word, SHALL go to SEND_HI.
REQ-018 On ser_out transfer of the last chunk (SEND_LO short, or SEND_HI), SHALL go to SEND_LO if a dec_in transfer occurs in the same cycle (back-to-back, no bubble), else IDLE.
REQ-019 SHALL hold ser_out.code, payload and v stable while ser_out.v=1 and ser_out.a=0.
REQ-020 SHALL drive ser_out.v=1 exactly in SEND_LO and SEND_HI.
REQ-021 SHALL increment words_sent by 1 per ser_out transfer, modulo 2^NCOUNT (all-ones wraps to 0).
REQ-022 SHALL sustain one ser_out transfer per cycle for continuous short words with ser_out.a held 1.
REQ-023 SHALL ignore payload[37:24] for short words (not transmitted).

Reset
REQ-024 While reset=1, SHALL force state IDLE, ser_out.v=0, ser_out.code=0, ser_out.payload=0, words_sent=0, dec_in.a=0.
REQ-025 SHALL abandon any in-flight word on reset assertion (no partial chunk re-sent after reset).
REQ-026 SHALL assert dec_in.a=1 in the first clock cycle after reset deasserts.

Verification
REQ-027 Short word: LONG_LEAF_MASK=0, send leaf 3, payload 38'h0000ABCDEF, ser_out.a=1 -> one cycle later code=8'h30, payload=24'hABCDEF, words_sent=1.
REQ-028 Long word: mask bit 5 set, leaf 5, payload 38'h3F_FF12_3456 -> code 8'h52 payload 24'h123456, next cycle code 8'h53 payload 24'h003FFF, words_sent=2.
REQ-029 Backpressure: ser_out.a=0 for 5 cycles during SEND_HI -> outputs stable, dec_in.a=0, one transfer when a=1.
REQ-030 Streaming: 8 consecutive short words with dec_in.v=1, ser_out.a=1 -> 8 transfers in 8 consecutive cycles, words_sent=8.
REQ-031 Reset mid-operation: assert reset in SEND_HI -> ser_out.v=0 immediately, words_sent=0, no HI chunk after release.
REQ-032 Wrap: NCOUNT=4, 17 short words -> words_sent=1.
